// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared widths and word/address types for the register bank
package regbank_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regbank_rdport.sv
// rtl/regbank_rdport.sv - combinational read mux selecting one word from the bank
module regbank_rdport #(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int ADDR_W = regbank_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  assign data = regs[addr];
endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 16 x 9 register file, one synchronous write port, two async read ports
module reg_bank #(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int ADDR_W = regbank_pkg::ADDR_W
) (
  output logic [DATA_W-1:0] dsr1,
  output logic [DATA_W-1:0] dsr2,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic              write,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] din,
  input  logic              clk,
  input  logic              rst
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Reset wins over a same-edge write; no bypass, so reads see the old word until the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write) begin
      regs[dr] <= din;
    end
  end

  regbank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs (regs),
    .addr (sr1),
    .data (dsr1)
  );

  regbank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs (regs),
    .addr (sr2),
    .data (dsr2)
  );
endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - scoreboard bench for reg_bank read/write/reset behaviour
module tb_reg_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic [3:0] sr1, sr2, dr;
  logic [8:0] din;
  logic [8:0] dsr1, dsr2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    bit         port;
    logic [8:0] v;
  } exp_t;

  exp_t sbq[$];

  reg_bank dut (
    .dsr1  (dsr1),
    .dsr2  (dsr2),
    .sr1   (sr1),
    .sr2   (sr2),
    .write (write),
    .dr    (dr),
    .din   (din),
    .clk   (clk),
    .rst   (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input bit port, input logic [8:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.v    = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, e.port ? dsr2 : dsr1, e.v);
    end
  endtask

  task automatic read2(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [8:0] e1, input logic [8:0] e2);
    sr1 = a;
    sr2 = b;
    push($sformatf("%s_p1_a%0d", tag, a), 1'b0, e1);
    push($sformatf("%s_p2_a%0d", tag, b), 1'b1, e2);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; write = 1'b0; sr1 = '0; sr2 = '0; dr = '0; din = '0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) read2("reset", 4'(i), 4'(15 - i), 9'h000, 9'h000);

    write = 1'b1;
    for (int d = 0; d < 10; d++) begin
      dr  = 4'(d);
      din = 9'h0A0 + 9'(d);
      tick();
    end
    write = 1'b0;
    for (int i = 0; i < 10; i++) read2("wsweep", 4'(i), 4'(i), 9'h0A0 + 9'(i), 9'h0A0 + 9'(i));
    for (int i = 10; i < 16; i++) read2("untouched", 4'(i), 4'(i), 9'h000, 9'h000);

    write = 1'b0; dr = 4'd3; din = 9'h1FF;
    repeat (3) tick();
    read2("wdis", 4'd3, 4'd3, 9'h0A3, 9'h0A3);

    dr = 4'd5; din = 9'h155; write = 1'b1;
    read2("rw_before", 4'd5, 4'd5, 9'h0A5, 9'h0A5);
    tick();
    write = 1'b0;
    read2("rw_after", 4'd5, 4'd5, 9'h155, 9'h155);

    read2("dual", 4'd2, 4'd7, 9'h0A2, 9'h0A7);
    read2("same", 4'd4, 4'd4, 9'h0A4, 9'h0A4);

    rst = 1'b1; write = 1'b1; dr = 4'd8; din = 9'h0FF;
    tick();
    rst = 1'b0; write = 1'b0;
    for (int i = 0; i < 16; i++) read2("rstprio", 4'(i), 4'(15 - i), 9'h000, 9'h000);

    write = 1'b1; dr = 4'd8; din = 9'h0FF;
    tick();
    write = 1'b0;
    read2("post_rst", 4'd8, 4'd0, 9'h0FF, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register file for the datapath: 16 registers of 9 bits, one synchronous write port and two independent combinational read ports. Source-register addresses feed the two read ports that supply operands; the destination-register address and write data come from writeback.

## Interface
Parameters:
- DATA_W, 9: register width in bits.
- ADDR_W, 4: address width; depth is 2**ADDR_W = 16.

Ports:
- clk, input, 1: clock. All state updates happen on the rising edge.
- rst, input, 1: reset. Synchronous and active-high.
- dsr1, output, DATA_W: read data for port 1, equal to the contents of register sr1.
- dsr2, output, DATA_W: read data for port 2, equal to the contents of register sr2.
- sr1, input, ADDR_W: read address for port 1.
- sr2, input, ADDR_W: read address for port 2.
- write, input, 1: write enable, active-high.
- dr, input, ADDR_W: write (destination) address.
- din, input, DATA_W: write data.

Positional port order is fixed: dsr1, dsr2, sr1, sr2, write, dr, din, clk, rst.

## Operation
- Storage is 16 × DATA_W flip-flop registers, R0 to R15. No register is hardwired; R0 is writable like the others.
- Write port:
  - At a rising clk edge with rst=0 and write=1, R[dr] takes din.
  - With write=0, no register changes.
- Read ports:
  - dsr1 = R[sr1] and dsr2 = R[sr2], purely combinational.
  - The two ports are fully independent and may address the same register.
- Reset: at a rising clk edge with rst=1, all 16 registers clear to 0.
  - Reset takes priority over a simultaneous write; that write is discarded.
  - dsr1 and dsr2 read 0 after the reset edge, for any address.
- din is truncated or zero-extended by the source to exactly DATA_W bits. The block does no arithmetic.
- X or Z on sr1/sr2 may produce X on the corresponding output. X on dr with write=1 is a caller error; no protection is required.

## Timing
- Write latency is 1 cycle: the value written at edge N is visible on a read port immediately after edge N.
- There is no write-to-read bypass. If sr1 or sr2 equals dr while write=1 in the same cycle, the read port shows the old contents until the edge, then the new value.
- Read latency is 0 cycles: the outputs follow sr1/sr2 combinationally within the same cycle.
- Reset mid-operation clears all contents on that edge. The first write accepted is at the next edge with rst=0.
- Reset value of every output: 0, once at least one reset edge has occurred.
- Before the first reset, contents are undefined. Simulation may show X.

## Structure
- Shared package (regbank_pkg) holds:
  - DATA_W = 9 and ADDR_W = 4 as localparams.
  - A typedef for a register word (logic [DATA_W-1:0]).
  - A typedef for a register address (logic [ADDR_W-1:0]).
- Single module. Storage is an array of words with one clocked write process and two continuous-assign read muxes.
- An optional sub-module, regbank_rdport (16:1 read mux), may be instantiated twice. It is not required.

## Test plan
- Reset: assert rst for one edge, then sweep sr1 and sr2 over 0..15 → dsr1 = dsr2 = 0 for every address.
- Write sweep: write=1, and for dr = 0..9 drive din = 9'h0A0+dr, one per cycle. Then write=0 and sweep sr1 over 0..9 → dsr1 = 9'h0A0+sr1. Sweep sr2 over the same range → identical values. Registers 10..15 still read 0.
- Write disabled: write=0, dr=3, din=9'h1FF for several cycles → R3 still reads 9'h0A3 on both ports.
- Same-cycle read/write: sr1=5, dr=5, din=9'h155, write=1:
  - before the edge, dsr1 shows the old 9'h0A5;
  - after the edge, dsr1 = 9'h155;
  - dsr2 at sr2=5 matches.
- Dual-port independence: sr1=2 and sr2=7 in the same cycle → dsr1=9'h0A2 and dsr2=9'h0A7 simultaneously. With sr1=sr2=4, both outputs = 9'h0A4.
- Reset priority mid-run: rst=1 with write=1, dr=8, din=9'h0FF on the same edge → after the edge, R8 and all other registers read 0. The next edge with rst=0, write=1, dr=8 stores 9'h0FF.
